foc_sequencer: RTL and testbench
================================

# foc_sequencer

Per-PWM-period scheduler for the FOC current-loop datapath. On each PWM sync trigger it runs the six compute stages (ADC capture, Clark, Park, PI, inverse Park, SVPWM) strictly in order. It uses each stage's level-enable / done-pulse handshake. It also reports completion, trigger overrun and per-stage timeout faults to the supervisor.

## Interface
- TIMEOUT_CYC, 64: cycles a stage may keep its enable high without signalling done (watchdog limit).
- iClk  in  1  system clock, all logic on rising edge.
- iRst_n  in  1  asynchronous, active-low reset.
- iEnable  in  1  run permission; gates new sequence starts only.
- iTrig  in  1  PWM period sync; rising edge starts a sequence.
- iStage_done  in  6  per-stage done pulse, bit k = stage k (0 ADC, 1 Clark, 2 Park, 3 PI, 4 IPark, 5 SVPWM).
- iFault_clr  in  1  pulse; clears fault and overrun flags.
- oStage_en  out  6  per-stage enable, at most one bit high.
- oBusy  out  1  high whenever state is not IDLE or FAULT.
- oCycle_done  out  1  one-cycle pulse after stage 5 completes.
- oOverrun  out  1  sticky; trigger arrived while busy.
- oFault  out  1  sticky; stage watchdog expired.
- oFault_stage  out  3  index of the timed-out stage, valid while oFault.

## Operation
- States: IDLE, RUN (stage enable high, awaiting done), GAP (all enables low for one cycle), FAULT.
- Trigger edge detect: iTrig registered; start when iTrig=1 and prev=0.
- IDLE: start with iEnable=1 → RUN, stage=0. Start with iEnable=0 → ignored, no flag.
- RUN: oStage_en[stage]=1. iStage_done[stage] sampled high → enable drops.
  - stage<5 → GAP.
  - stage=5 → oCycle_done pulse, IDLE.
- GAP: stage+1 → RUN. The gap guarantees a fresh rising enable edge for the edge-detecting stages.
- iStage_done bits of non-active stages are ignored in every state.
- Watchdog: counter cleared on entry to RUN and increments each RUN cycle. Reaching TIMEOUT_CYC with no done → FAULT.
- FAULT: all enables 0, oFault=1, oFault_stage=stage. Triggers are ignored and do not set overrun. iFault_clr → IDLE.
- Overrun: a start edge in RUN/GAP sets oOverrun and is otherwise dropped; the running sequence continues.
- iFault_clr outside FAULT clears oOverrun only.
- iEnable falling mid-sequence: the sequence runs to completion.

## Timing
- Reset: all outputs 0, state IDLE, stage 0, watchdog 0, trigger history 0.
- Reset mid-sequence immediately zeroes all enables; no done pulse is produced.
- Latency: trigger rising edge sampled at edge N → oStage_en[0] high after edge N+1.
- Done of stage k sampled at edge M:
  - oStage_en[k] low after M.
  - oStage_en[k+1] high after M+1.
  - For k=5, oCycle_done high during cycle M..M+1.
- Sequence length = 1 + Σ(d_k) + 5, where d_k = enable-high cycles of stage k.
- Simultaneous done and watchdog expiry on the same edge: done wins.
- Trigger edge on the same edge as the final done: state is still RUN → overrun set, trigger lost.
- iFault_clr and a start edge on the same edge in FAULT: go to IDLE; the trigger is not taken.

## Configuration
- FOC_SEQ_TIMEOUT_EN defined: watchdog and FAULT state present, behaviour as above.
- FOC_SEQ_TIMEOUT_EN undefined:
  - No watchdog counter; RUN waits indefinitely.
  - oFault and oFault_stage tied 0.
  - iFault_clr clears oOverrun only.
  - TIMEOUT_CYC unused.

## Structure
- Shared package foc_pkg holds:
  - stage index constants (STG_ADC=0 … STG_SVPWM=5) and FOC_NSTAGE=6;
  - sequencer state encoding;
  - watchdog counter width, derived as clog2(TIMEOUT_CYC+1).
- One sub-module: foc_seq_watchdog (clear, count-enable, expired output).
  - Instantiated only under FOC_SEQ_TIMEOUT_EN.

## Test plan
- Nominal run:
  - Stimulus: iEnable=1, trigger pulse; each stage returns done 3 cycles after its enable rises.
  - Response: enables 0→5 in order, each high 3 cycles with 1 low cycle between; oCycle_done pulses once, 24 cycles after the trigger edge sample; oBusy high throughout.
- Gating: iEnable=0 with trigger → no enable ever rises, no flags set.
- Overrun:
  - Stimulus: second trigger while stage 2 is running.
  - Response: oOverrun=1, sequence completes normally, no second sequence starts.
  - Stimulus: iFault_clr. Response: oOverrun=0.
- Timeout (FOC_SEQ_TIMEOUT_EN, TIMEOUT_CYC=8):
  - Stimulus: Park never signals done.
  - Response: after 8 RUN cycles, oStage_en=0, oFault=1, oFault_stage=2; later triggers ignored.
  - Stimulus: iFault_clr, then trigger. Response: a new sequence starts at stage 0.
- Spurious done: iStage_done[4] pulse while stage 1 is active → ignored; order and timing unchanged.
- Reset mid-run: iRst_n low during stage 3 → all outputs 0 at once; after release, IDLE with no oCycle_done.

Source files
------------

// File: rtl/foc_pkg.sv
// ---------------------------------------------------------------------------
// foc_pkg
// Shared definitions for the FOC current-loop sequencer:
//   - stage index constants (ADC .. SVPWM) and the stage count
//   - sequencer state encoding (exposed on the debug state port)
//   - helper that derives the watchdog counter width from the timeout limit
// ---------------------------------------------------------------------------
package foc_pkg;

  localparam int FOC_NSTAGE = 6;

  localparam logic [2:0] STG_ADC   = 3'd0;
  localparam logic [2:0] STG_CLARK = 3'd1;
  localparam logic [2:0] STG_PARK  = 3'd2;
  localparam logic [2:0] STG_PI    = 3'd3;
  localparam logic [2:0] STG_IPARK = 3'd4;
  localparam logic [2:0] STG_SVPWM = 3'd5;

  localparam int TIMEOUT_CYC_DEF = 64;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_GAP   = 2'd2,
    ST_FAULT = 2'd3
  } seq_state_t;

  // Counter must be able to hold TIMEOUT_CYC itself.
  function automatic int wdog_width(input int timeout_cyc);
    return $clog2(timeout_cyc + 1);
  endfunction

endpackage

// File: rtl/foc_seq_watchdog.sv
// ---------------------------------------------------------------------------
// foc_seq_watchdog
// Per-stage watchdog for the FOC sequencer. Counts cycles while the active
// stage holds its enable high and flags expiry on the cycle that would be
// the TIMEOUT_CYC-th enabled cycle.
// Ports:
//   iClk, iRst_n  clock, asynchronous active-low reset
//   i_clr         synchronous clear (priority over counting)
//   i_cnt_en      count this cycle (stage enable high)
//   o_expired     combinational: this is the last allowed enabled cycle
// ---------------------------------------------------------------------------
module foc_seq_watchdog
  import foc_pkg::*;
#(
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic iClk,
  input  logic iRst_n,
  input  logic i_clr,
  input  logic i_cnt_en,
  output logic o_expired
);

  localparam int WD_W = wdog_width(TIMEOUT_CYC);

  logic [WD_W-1:0] r_cnt;

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_cnt_en) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // r_cnt holds the number of enabled cycles already completed, so the
  // stage has had its full TIMEOUT_CYC cycles when this edge is reached.
  assign o_expired = i_cnt_en && (r_cnt == WD_W'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/foc_sequencer.sv
// ---------------------------------------------------------------------------
// foc_sequencer
// Per-PWM-period scheduler: on a rising PWM sync edge it runs the six FOC
// compute stages in order using a level-enable / done-pulse handshake, with
// one all-low gap cycle between stages so each stage sees a fresh enable edge.
//
// Handshake: oStage_en[k] is held high while stage k runs; the stage answers
// with a single-cycle iStage_done[k]; only the done bit of the active stage is
// honoured, all others are ignored.
//
// Build option FOC_SEQ_TIMEOUT_EN: when defined, a per-stage watchdog moves
// the sequencer to FAULT after TIMEOUT_CYC enabled cycles without done.
// When undefined, RUN waits indefinitely and oFault/oFault_stage are 0.
//
// Ports:
//   iClk, iRst_n   clock, asynchronous active-low reset
//   iEnable        gates new sequence starts only
//   iTrig          PWM sync, rising edge starts a sequence
//   iStage_done    per-stage done pulses
//   iFault_clr     clears fault (leaves FAULT) and overrun
//   oStage_en      one-hot (or zero) stage enables
//   oBusy          state is RUN or GAP
//   oCycle_done    one-cycle pulse after stage 5 completes
//   oOverrun       sticky: start edge seen while busy
//   oFault         sticky: stage watchdog expired
//   oFault_stage   timed-out stage, valid while oFault
//   oDbg_state     current FSM state
// ---------------------------------------------------------------------------
module foc_sequencer
  import foc_pkg::*;
#(
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic                  iClk,
  input  logic                  iRst_n,
  input  logic                  iEnable,
  input  logic                  iTrig,
  input  logic [FOC_NSTAGE-1:0] iStage_done,
  input  logic                  iFault_clr,
  output logic [FOC_NSTAGE-1:0] oStage_en,
  output logic                  oBusy,
  output logic                  oCycle_done,
  output logic                  oOverrun,
  output logic                  oFault,
  output logic [2:0]            oFault_stage,
  output seq_state_t            oDbg_state
);

  if (TIMEOUT_CYC < 1) begin : g_bad_cfg
    $error("foc_sequencer: TIMEOUT_CYC must be at least 1");
  end

  seq_state_t r_state, w_state_nxt;
  logic [2:0] r_stage, w_stage_nxt;
  logic       r_trig, r_trig_prev;
  logic       r_cycle_done, w_cycle_done_nxt;
  logic       r_overrun;

  logic [FOC_NSTAGE-1:0] w_stage_onehot;
  logic                  w_start;
  logic                  w_done_cur;
  logic                  w_busy;
  logic                  w_wd_expired;

  // Start is derived from the registered trigger history, which gives the
  // one-cycle trigger-to-enable latency.
  assign w_start        = r_trig && !r_trig_prev;
  assign w_stage_onehot = FOC_NSTAGE'(1) << r_stage;
  assign w_done_cur     = |(iStage_done & w_stage_onehot);
  assign w_busy         = (r_state == ST_RUN) || (r_state == ST_GAP);

`ifdef FOC_SEQ_TIMEOUT_EN
  foc_seq_watchdog #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_watchdog (
    .iClk      (iClk),
    .iRst_n    (iRst_n),
    .i_clr     (r_state != ST_RUN),
    .i_cnt_en  (r_state == ST_RUN),
    .o_expired (w_wd_expired)
  );
`else
  assign w_wd_expired = 1'b0;
`endif

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      r_state      <= ST_IDLE;
      r_stage      <= STG_ADC;
      r_trig       <= 1'b0;
      r_trig_prev  <= 1'b0;
      r_cycle_done <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_stage      <= w_stage_nxt;
      r_trig       <= iTrig;
      r_trig_prev  <= r_trig;
      r_cycle_done <= w_cycle_done_nxt;
      // A dropped start wins over a clear arriving on the same edge.
      if (w_busy && w_start) begin
        r_overrun <= 1'b1;
      end else if (iFault_clr) begin
        r_overrun <= 1'b0;
      end
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_stage_nxt      = r_stage;
    w_cycle_done_nxt = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_start && iEnable) begin
          w_state_nxt = ST_RUN;
          w_stage_nxt = STG_ADC;
        end
      end
      ST_RUN: begin
        // Done has priority over a watchdog expiry on the same edge.
        if (w_done_cur) begin
          if (r_stage == STG_SVPWM) begin
            w_state_nxt      = ST_IDLE;
            w_stage_nxt      = STG_ADC;
            w_cycle_done_nxt = 1'b1;
          end else begin
            w_state_nxt = ST_GAP;
          end
        end else if (w_wd_expired) begin
          w_state_nxt = ST_FAULT;
        end
      end
      ST_GAP: begin
        w_state_nxt = ST_RUN;
        w_stage_nxt = r_stage + 3'd1;
      end
      ST_FAULT: begin
        // r_stage is frozen here so it can report the offending stage.
        if (iFault_clr) begin
          w_state_nxt = ST_IDLE;
          w_stage_nxt = STG_ADC;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_stage_nxt = STG_ADC;
      end
    endcase
  end

  // Enables decode straight from state so an async reset drops them at once.
  assign oStage_en   = (r_state == ST_RUN) ? w_stage_onehot : '0;
  assign oBusy       = w_busy;
  assign oCycle_done = r_cycle_done;
  assign oOverrun    = r_overrun;
  assign oDbg_state  = r_state;

`ifdef FOC_SEQ_TIMEOUT_EN
  assign oFault       = (r_state == ST_FAULT);
  assign oFault_stage = (r_state == ST_FAULT) ? r_stage : 3'd0;
`else
  assign oFault       = 1'b0;
  assign oFault_stage = 3'd0;
`endif

endmodule

// File: tb/tb_foc_sequencer.sv
// ---------------------------------------------------------------------------
// tb_foc_sequencer
// Self-checking bench for foc_sequencer (built with TIMEOUT_CYC=8). A stage
// responder returns done d_cfg[k] cycles after each enable rises; expected
// enable-rise and cycle-done events (event code, cycle) are queued when a
// trigger is driven and compared as the DUT produces them.
// ---------------------------------------------------------------------------
module tb_foc_sequencer;
  import foc_pkg::*;

  logic       iClk = 1'b0;
  logic       iRst_n = 1'b0;
  logic       iEnable = 1'b0;
  logic       iTrig = 1'b0;
  logic       iFault_clr = 1'b0;
  logic [5:0] iStage_done;
  logic [5:0] resp_done = '0;
  logic [5:0] spur_done = '0;
  logic [5:0] oStage_en;
  logic       oBusy, oCycle_done, oOverrun, oFault;
  logic [2:0] oFault_stage;
  seq_state_t oDbg_state;

  assign iStage_done = resp_done | spur_done;

  foc_sequencer #(.TIMEOUT_CYC(8)) dut (
    .iClk         (iClk),
    .iRst_n       (iRst_n),
    .iEnable      (iEnable),
    .iTrig        (iTrig),
    .iStage_done  (iStage_done),
    .iFault_clr   (iFault_clr),
    .oStage_en    (oStage_en),
    .oBusy        (oBusy),
    .oCycle_done  (oCycle_done),
    .oOverrun     (oOverrun),
    .oFault       (oFault),
    .oFault_stage (oFault_stage),
    .oDbg_state   (oDbg_state)
  );

  // ---------------- clock / reset / cycle counter ----------------
  always #5 iClk = ~iClk;

  int cyc = 0;
  initial forever begin
    @(posedge iClk);
    cyc = cyc + 1;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "simulation time limit");
  end

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad = 0;
  logic [31:0] exp_q[$];
  int d_cfg[6] = '{3, 3, 3, 3, 3, 3};
  logic [5:0] stall = '0;
  int last_done_cyc = -1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  function automatic int idx_of(input logic [5:0] v);
    int r = 0;
    for (int i = 0; i < 6; i++) if (v[i]) r = i;
    return r;
  endfunction

  task automatic sb_pop(input logic [31:0] ev);
    logic [31:0] e;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL unexpected_event got=%0h exp=none", ev);
    end else begin
      e = exp_q.pop_front();
      if (e !== ev) begin
        bad++;
        $display("FAIL event got=%0h exp=%0h", ev, e);
      end
    end
  endtask

  // Model: stage k enable rises after edge t, done sampled at t+d_k,
  // next stage rises one gap cycle later. Event code 0x0k = enable k rise,
  // 0x10 = cycle done.
  task automatic push_seq(input int n, input int last_stage, input bit with_done);
    int t = n + 1;
    int done_at = 0;
    for (int k = 0; k <= last_stage; k++) begin
      exp_q.push_back({8'(k), 24'(t)});
      done_at = t + d_cfg[k];
      t = done_at + 1;
    end
    if (with_done) exp_q.push_back({8'h10, 24'(done_at)});
  endtask

  // ---------------- monitor ----------------
  initial begin
    logic [5:0] prev_en;
    prev_en = '0;
    forever begin
      @(negedge iClk);
      check("onehot", 32'($countones(oStage_en) <= 1), 32'd1);
      if (oStage_en != 0 && prev_en == 0) sb_pop({8'(idx_of(oStage_en)), 24'(cyc)});
      if (oCycle_done) begin
        last_done_cyc = cyc;
        sb_pop({8'h10, 24'(cyc)});
      end
      prev_en = oStage_en;
    end
  end

  // ---------------- stage responder ----------------
  initial begin
    int act_k, act_cnt, k;
    bit was_on;
    act_k = 0; act_cnt = 0; was_on = 0;
    forever begin
      @(negedge iClk);
      resp_done = '0;
      if (oStage_en != 0) begin
        k = idx_of(oStage_en);
        if (!was_on || k != act_k) act_cnt = 1;
        else act_cnt++;
        act_k = k;
        was_on = 1;
        if (!stall[k] && act_cnt == d_cfg[k]) resp_done[k] = 1'b1;
      end else begin
        was_on = 0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic pulse_trig(output int n);
    @(negedge iClk);
    iTrig = 1'b1;
    n = cyc + 1;
    @(negedge iClk);
    iTrig = 1'b0;
  endtask

  task automatic pulse_clr();
    @(negedge iClk);
    iFault_clr = 1'b1;
    @(negedge iClk);
    iFault_clr = 1'b0;
  endtask

  task automatic wait_en(input int k, input string name);
    int i = 0;
    while (!oStage_en[k] && i < 200) begin
      @(negedge iClk);
      i++;
    end
    check(name, 32'(oStage_en[k]), 32'd1);
  endtask

  task automatic drain(input string name);
    int i = 0;
    while ((exp_q.size() != 0 || oBusy) && i < 300) begin
      @(negedge iClk);
      i++;
    end
    check(name, 32'(exp_q.size()), 32'd0);
    repeat (3) @(negedge iClk);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge iClk);
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    bit en;
    int d[6];
    int exp_len;
  } vec_t;

  vec_t vecs[4];

  initial begin
    int n, n2, hi;

    vecs[0] = '{en: 1'b1, d: '{3, 3, 3, 3, 3, 3}, exp_len: 24};
    vecs[1] = '{en: 1'b1, d: '{1, 2, 1, 4, 2, 1}, exp_len: 17};
    vecs[2] = '{en: 1'b0, d: '{3, 3, 3, 3, 3, 3}, exp_len: 0};
    vecs[3] = '{en: 1'b1, d: '{5, 1, 1, 1, 1, 3}, exp_len: 18};

    // Reset state
    idle(2);
    check("rst_en", 32'(oStage_en), 32'd0);
    check("rst_busy", 32'(oBusy), 32'd0);
    check("rst_cdone", 32'(oCycle_done), 32'd0);
    check("rst_ovr", 32'(oOverrun), 32'd0);
    check("rst_fault", 32'(oFault), 32'd0);
    check("rst_fstage", 32'(oFault_stage), 32'd0);
    check("rst_state", 32'(oDbg_state), 32'(ST_IDLE));
    iRst_n = 1'b1;
    idle(3);

    // Table-driven runs
    for (int i = 0; i < 4; i++) begin
      d_cfg = vecs[i].d;
      iEnable = vecs[i].en;
      last_done_cyc = -1;
      pulse_trig(n);
      if (vecs[i].en) begin
        push_seq(n, 5, 1'b1);
        wait_en(0, $sformatf("vec%0d_start", i));
        check($sformatf("vec%0d_busy", i), 32'(oBusy), 32'd1);
        drain($sformatf("vec%0d_drain", i));
        check($sformatf("vec%0d_len", i), 32'(last_done_cyc - n), 32'(vecs[i].exp_len));
      end else begin
        idle(20);
        check($sformatf("vec%0d_gated_busy", i), 32'(oBusy), 32'd0);
      end
      check($sformatf("vec%0d_ovr", i), 32'(oOverrun), 32'd0);
      check($sformatf("vec%0d_idle", i), 32'(oDbg_state), 32'(ST_IDLE));
    end

    // Overrun during stage 2
    d_cfg = '{3, 3, 3, 3, 3, 3};
    iEnable = 1'b1;
    pulse_trig(n);
    push_seq(n, 5, 1'b1);
    wait_en(2, "ovr_wait_s2");
    pulse_trig(n2);
    idle(2);
    check("ovr_set", 32'(oOverrun), 32'd1);
    drain("ovr_drain");
    idle(10);
    check("ovr_sticky", 32'(oOverrun), 32'd1);
    pulse_clr();
    idle(1);
    check("ovr_clr", 32'(oOverrun), 32'd0);

    // Start edge evaluated on the same edge as the final done: dropped, overrun
    pulse_trig(n);
    push_seq(n, 5, 1'b1);
    wait_en(5, "fin_wait_s5");
    @(negedge iClk);
    iTrig = 1'b1;  // sampled one edge before done; start evaluated at the done edge
    @(negedge iClk);
    iTrig = 1'b0;
    drain("fin_drain");
    idle(10);
    check("fin_ovr", 32'(oOverrun), 32'd1);
    check("fin_idle", 32'(oBusy), 32'd0);
    pulse_clr();

    // Spurious done of stage 4 while stage 1 runs
    pulse_trig(n);
    push_seq(n, 5, 1'b1);
    wait_en(1, "spur_wait_s1");
    spur_done = 6'b010000;
    @(negedge iClk);
    spur_done = '0;
    drain("spur_drain");

    // Reset during stage 3
    pulse_trig(n);
    push_seq(n, 5, 1'b1);
    wait_en(3, "rst_wait_s3");
    #2;
    iRst_n = 1'b0;
    #1;
    check("mrst_en", 32'(oStage_en), 32'd0);
    check("mrst_busy", 32'(oBusy), 32'd0);
    check("mrst_state", 32'(oDbg_state), 32'(ST_IDLE));
    exp_q.delete();
    idle(2);
    iRst_n = 1'b1;
    idle(30);
    check("mrst_after", 32'(oDbg_state), 32'(ST_IDLE));
    check("mrst_q", 32'(exp_q.size()), 32'd0);

`ifdef FOC_SEQ_TIMEOUT_EN
    // Park never answers: 8 enabled cycles then FAULT
    stall = 6'b000100;
    pulse_trig(n);
    push_seq(n, 2, 1'b0);
    wait_en(2, "to_wait_s2");
    hi = 0;
    while (oStage_en[2] && hi < 50) begin
      hi++;
      @(negedge iClk);
    end
    check("to_hi_cycles", 32'(hi), 32'd8);
    check("to_en", 32'(oStage_en), 32'd0);
    check("to_fault", 32'(oFault), 32'd1);
    check("to_fstage", 32'(oFault_stage), 32'd2);
    check("to_busy", 32'(oBusy), 32'd0);
    pulse_trig(n2);
    idle(10);
    check("to_trig_ign", 32'(oDbg_state), 32'(ST_FAULT));
    check("to_no_ovr", 32'(oOverrun), 32'd0);
    // Clear and start edge on the same edge: back to IDLE, trigger not taken
    stall = '0;
    @(negedge iClk);
    iTrig = 1'b1;
    @(negedge iClk);
    iTrig = 1'b0;
    iFault_clr = 1'b1;
    @(negedge iClk);
    iFault_clr = 1'b0;
    idle(10);
    check("to_clr_fault", 32'(oFault), 32'd0);
    check("to_clr_idle", 32'(oDbg_state), 32'(ST_IDLE));
    pulse_trig(n);
    push_seq(n, 5, 1'b1);
    drain("to_restart");
`else
    // Without the watchdog a silent stage holds RUN indefinitely
    stall = 6'b000100;
    pulse_trig(n);
    push_seq(n, 2, 1'b0);
    wait_en(2, "nto_wait_s2");
    idle(40);
    check("nto_en", 32'(oStage_en), 32'h4);
    check("nto_fault", 32'(oFault), 32'd0);
    check("nto_busy", 32'(oBusy), 32'd1);
    check("nto_q", 32'(exp_q.size()), 32'd0);
    iRst_n = 1'b0;
    stall = '0;
    idle(2);
    iRst_n = 1'b1;
    idle(5);
    check("nto_rst_idle", 32'(oDbg_state), 32'(ST_IDLE));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
